// File: rtl/count_checker_if.sv
// ---------------------------------------------------------------------------
// count_checker_if
// Bundles the signals exchanged between a monitored up/down counter
// environment and the count_checker block.
//   mode         counter direction (1 = up, 0 = down)
//   cnt_in       counter output being monitored
//   clr          synchronous clear of the sticky flag and debug tallies
//   locked       checker is tracking the counter
//   err          one-cycle pulse per step error while tracking
//   err_sticky   latched error indication
//   err_cnt      saturating error tally
//   wrap_up_cnt  saturating tally of MAX -> 0 wraps
//   wrap_dn_cnt  saturating tally of 0 -> MAX wraps
// The master side drives mode/cnt_in/clr; the slave side is the checker.
// ---------------------------------------------------------------------------
interface count_checker_if #(
  parameter int WIDTH = 4
);
  logic             mode;
  logic [WIDTH-1:0] cnt_in;
  logic             clr;
  logic             locked;
  logic             err;
  logic             err_sticky;
  logic [7:0]       err_cnt;
  logic [7:0]       wrap_up_cnt;
  logic [7:0]       wrap_dn_cnt;

  modport master (
    output mode, cnt_in, clr,
    input  locked, err, err_sticky, err_cnt, wrap_up_cnt, wrap_dn_cnt
  );

  modport slave (
    input  mode, cnt_in, clr,
    output locked, err, err_sticky, err_cnt, wrap_up_cnt, wrap_dn_cnt
  );
endinterface

// File: rtl/count_checker.sv
// ---------------------------------------------------------------------------
// count_checker
// Passive monitor for a WIDTH-bit up/down counter. Every rising edge it
// compares the counter value against the previous sample stepped one in
// the direction selected by the previous MODE sample. After LOCK_LEN
// consecutive good steps it enters TRACK; any bad step in TRACK raises a
// one-cycle err pulse, bumps the error tally and drops back to SYNC.
// Correct MAX->0 and 0->MAX wraps are tallied in either state.
// Ports:
//   clk    rising-edge clock shared with the counter
//   rst_n  asynchronous active-low reset
//   bus    count_checker_if slave modport (inputs mode/cnt_in/clr,
//          outputs locked/err/err_sticky/err_cnt/wrap_up_cnt/wrap_dn_cnt)
// ---------------------------------------------------------------------------
module count_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  count_checker_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [7:0]       SAT  = 8'd255;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       match_cnt;
  logic [3:0]       match_cnt_next;
  logic [WIDTH-1:0] prev_cnt;
  logic             prev_mode;
  logic             have_prev;

  logic [WIDTH-1:0] expected;
  logic             step_ok;
  logic             err_det;
  logic             up_wrap;
  logic             dn_wrap;
  logic [4:0]       match_inc;

  logic             err_q;
  logic             err_sticky_q;
  logic [7:0]       err_cnt_q;
  logic [7:0]       wrap_up_q;
  logic [7:0]       wrap_dn_q;

  // The counter applies MODE one edge late, so the expected value is built
  // from the previous sample and the previous MODE, not the current MODE.
  always_comb begin
    expected  = prev_mode ? (prev_cnt + 1'b1) : (prev_cnt - 1'b1);
    step_ok   = have_prev && (bus.cnt_in == expected);
    err_det   = (state == TRACK) && !step_ok;
    up_wrap   = step_ok && prev_mode  && (prev_cnt == MAX)  && (bus.cnt_in == ZERO);
    dn_wrap   = step_ok && !prev_mode && (prev_cnt == ZERO) && (bus.cnt_in == MAX);
    match_inc = {1'b0, match_cnt} + 5'd1;
  end

  // Next-state logic. match_cnt counts good steps while in SYNC and is
  // cleared by any bad step; leaving for TRACK happens on the good step that
  // completes the run. A bad step in TRACK is the only error source.
  always_comb begin
    state_next     = state;
    match_cnt_next = match_cnt;
    case (state)
      SYNC: begin
        if (step_ok) begin
          match_cnt_next = (match_cnt == 4'hF) ? match_cnt : match_inc[3:0];
          if (match_inc == 5'(LOCK_LEN)) begin
            state_next = TRACK;
          end
        end else begin
          match_cnt_next = 4'd0;
        end
      end
      TRACK: begin
        if (!step_ok) begin
          state_next     = SYNC;
          match_cnt_next = 4'd0;
        end
      end
      default: begin
        state_next     = SYNC;
        match_cnt_next = 4'd0;
      end
    endcase
  end

  // State register and lock run counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      match_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      match_cnt <= match_cnt_next;
    end
  end

  // Previous-sample registers; every edge captures a new sample, and the
  // first edge after reset only makes that sample valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cnt  <= '0;
      prev_mode <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      prev_cnt  <= bus.cnt_in;
      prev_mode <= bus.mode;
      have_prev <= 1'b1;
    end
  end

  // Error pulse, sticky flag and saturating tallies. clr wipes the debug
  // state, but an event on the same edge as clr still registers as the
  // first event after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= 8'd0;
      wrap_up_q    <= 8'd0;
      wrap_dn_q    <= 8'd0;
    end else begin
      err_q <= err_det;
      if (bus.clr) begin
        err_sticky_q <= err_det;
        err_cnt_q    <= {7'd0, err_det};
        wrap_up_q    <= {7'd0, up_wrap};
        wrap_dn_q    <= {7'd0, dn_wrap};
      end else begin
        if (err_det) begin
          err_sticky_q <= 1'b1;
        end
        if (err_det && (err_cnt_q != SAT)) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
        if (up_wrap && (wrap_up_q != SAT)) begin
          wrap_up_q <= wrap_up_q + 8'd1;
        end
        if (dn_wrap && (wrap_dn_q != SAT)) begin
          wrap_dn_q <= wrap_dn_q + 8'd1;
        end
      end
    end
  end

  assign bus.locked      = (state == TRACK);
  assign bus.err         = err_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.wrap_up_cnt = wrap_up_q;
  assign bus.wrap_dn_cnt = wrap_dn_q;

endmodule

// File: tb/tb_count_checker.sv
// ---------------------------------------------------------------------------
// tb_count_checker
// Directed bench for count_checker (WIDTH = 4, LOCK_LEN = 2). Each stimulus
// vector carries hand-computed expected outputs that are queued when the
// vector is driven; a separate monitor pops one entry after every rising
// edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_count_checker;

  logic clk = 1'b1;
  logic rst_n;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string tag;
    int    locked;
    int    err;
    int    sticky;
    int    errcnt;
    int    wup;
    int    wdn;
  } exp_t;

  exp_t expq[$];

  count_checker_if #(.WIDTH(4)) bus ();

  count_checker #(
    .WIDTH   (4),
    .LOCK_LEN(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // 20 ns clock, rising edges at 20, 40, 60, ...
  initial begin
    forever #10 clk = ~clk;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #500us;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " locked"},     int'(bus.locked),      0);
    checkOutput({tag, " err"},        int'(bus.err),         0);
    checkOutput({tag, " err_sticky"}, int'(bus.err_sticky),  0);
    checkOutput({tag, " err_cnt"},    int'(bus.err_cnt),     0);
    checkOutput({tag, " wrap_up"},    int'(bus.wrap_up_cnt), 0);
    checkOutput({tag, " wrap_dn"},    int'(bus.wrap_dn_cnt), 0);
  endtask

  // Drive one sample for the next rising edge and queue what the outputs
  // must show right after that edge.
  task automatic applyStimulus(input string tag, input int cnt, input int mode, input int clr,
                               input int l, input int e, input int s, input int ec,
                               input int wu, input int wd);
    exp_t x;
    bus.cnt_in = 4'(cnt);
    bus.mode   = 1'(mode);
    bus.clr    = 1'(clr);
    x.tag    = tag;
    x.locked = l;
    x.err    = e;
    x.sticky = s;
    x.errcnt = ec;
    x.wup    = wu;
    x.wdn    = wd;
    expq.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: one expected entry is consumed per rising edge, sampled 1 ns
  // after the edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        checkOutput({x.tag, " locked"},     int'(bus.locked),      x.locked);
        checkOutput({x.tag, " err"},        int'(bus.err),         x.err);
        checkOutput({x.tag, " err_sticky"}, int'(bus.err_sticky),  x.sticky);
        checkOutput({x.tag, " err_cnt"},    int'(bus.err_cnt),     x.errcnt);
        checkOutput({x.tag, " wrap_up"},    int'(bus.wrap_up_cnt), x.wup);
        checkOutput({x.tag, " wrap_dn"},    int'(bus.wrap_dn_cnt), x.wdn);
      end
    end
  end

  initial begin : stimulus
    int wu;
    rst_n      = 1'b0;
    bus.cnt_in = 4'd0;
    bus.mode   = 1'b1;
    bus.clr    = 1'b0;

    // Outputs held at zero while reset is asserted, across clock edges.
    @(posedge clk);
    #1;
    checkAllZero("in reset A");
    @(posedge clk);
    #1;
    checkAllZero("in reset B");
    @(negedge clk);
    rst_n = 1'b1;

    // Lock: first edge samples only, LOCKED after the third edge.
    applyStimulus("first sample", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("step one",     1, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("lock",         2, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int c = 3; c <= 15; c++) begin
      applyStimulus("count up", c, 1, 0, 1, 0, 0, 0, 0, 0);
    end
    applyStimulus("up wrap",       0, 1, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus("after up wrap", 1, 1, 0, 1, 0, 0, 0, 1, 0);

    // Direction change at 3 (MODE takes effect one edge later), then down-wrap.
    applyStimulus("dir 2",     2,  1, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus("dir 3",     3,  1, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus("dir 4",     4,  0, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus("down 3",    3,  0, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus("down 2",    2,  0, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus("down 1",    1,  0, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus("down 0",    0,  0, 0, 1, 0, 0, 0, 1, 0);
    applyStimulus("down wrap", 15, 0, 0, 1, 0, 0, 0, 1, 1);
    for (int c = 14; c >= 6; c--) begin
      applyStimulus("count down", c, 0, 0, 1, 0, 0, 0, 1, 1);
    end

    // Injected jump 5 -> 9 while locked, re-lock with a mismatch in SYNC.
    applyStimulus("turn up 5",     5,  1, 0, 1, 0, 0, 0, 1, 1);
    applyStimulus("jump error",    9,  1, 0, 0, 1, 1, 1, 1, 1);
    applyStimulus("relock step",   10, 1, 0, 0, 0, 1, 1, 1, 1);
    applyStimulus("sync mismatch", 13, 1, 0, 0, 0, 1, 1, 1, 1);
    applyStimulus("relock 14",     14, 1, 0, 0, 0, 1, 1, 1, 1);
    applyStimulus("relocked",      15, 1, 0, 1, 0, 1, 1, 1, 1);
    applyStimulus("up wrap 2",     0,  1, 0, 1, 0, 1, 1, 2, 1);

    // Counter held at 0 for four edges: a single ERR, no lock.
    applyStimulus("hold error", 0, 1, 0, 0, 1, 1, 2, 2, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("hold", 0, 1, 0, 0, 0, 1, 2, 2, 1);
    end
    applyStimulus("resume 1", 1, 1, 0, 0, 0, 1, 2, 2, 1);
    applyStimulus("resume 2", 2, 1, 0, 1, 0, 1, 2, 2, 1);

    // 300 up-wraps; the up-wrap tally must stop at 255.
    wu = 2;
    for (int i = 0; i < 300 * 16; i++) begin
      if (((3 + i) % 16) == 0 && wu < 255) begin
        wu++;
      end
      applyStimulus("saturate", (3 + i) % 16, 1, 0, 1, 0, 1, 2, wu, 1);
    end

    // Plain clear, then clear coinciding with an error, then with a wrap.
    applyStimulus("clr",          3,  1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus("after clr",    4,  1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("pre err 5",    5,  1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("pre err 6",    6,  1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("clr with err", 9,  1, 1, 0, 1, 1, 1, 0, 0);
    applyStimulus("post clr err", 10, 1, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("relock 11",    11, 1, 0, 1, 0, 1, 1, 0, 0);
    for (int c = 12; c <= 15; c++) begin
      applyStimulus("to wrap", c, 1, 0, 1, 0, 1, 1, 0, 0);
    end
    applyStimulus("clr with wrap",  0, 1, 1, 1, 0, 0, 0, 1, 0);
    applyStimulus("post clr wrap",  1, 1, 0, 1, 0, 0, 0, 1, 0);

    @(posedge clk);
    #2;
    checkOutput("queue drained", expq.size(), 0);

    // Asynchronous reset mid-operation clears everything immediately.
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkAllZero("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("reset first", 5, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset step",  6, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("reset lock",  7, 1, 0, 1, 0, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    checkOutput("final queue drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
